if_fetch_stage: RTL

- Instruction-fetch front end of the 5-stage MIPS pipeline. Owns the PC and issues word requests to the synchronous-read instruction memory.
- Buffers returned instructions in a small skid FIFO and presents them to the IF/ID boundary with a valid/ready handshake.
- The ready input comes from the hazard unit's stall. Taken branches/jumps resolved downstream redirect the PC and flush all younger fetches.

---
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues word requests to a synchronous-read imem and
// buffers responses in a small skid FIFO toward ID. Optional perf counters: IF_PERF_COUNTERS_EN.
module if_fetch_stage #(
    parameter int                    PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = 32'h0000_0000,
    parameter int                    BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                id_ready,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [PC_WIDTH-1:0] if_pc4,
    output logic [31:0]         fetch_count,
    output logic [31:0]         flush_count
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] inflight_pc_reg;
    logic                inflight_reg;
    logic                kill_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic [31:0]         instr_buf [BUF_DEPTH];
    logic [PC_WIDTH-1:0] pc_buf    [BUF_DEPTH];

    logic                pop;
    logic                push;
    logic                live_rsp;
    logic [OCC_W-1:0]    occupancy;
    logic [PC_WIDTH-1:0] target_pc;

    assign if_valid  = (count_reg != '0);
    assign pop       = if_valid & id_ready;
    assign live_rsp  = inflight_reg & ~kill_reg;
    // A redirect drops the response arriving this cycle along with the FIFO contents.
    assign push      = live_rsp & ~redirect_valid;
    // Counts the slot of a request still in flight so a full FIFO can never be overrun.
    assign occupancy = OCC_W'(count_reg) + OCC_W'(inflight_reg) - OCC_W'(pop);
    assign imem_req  = ~reset & ~redirect_valid & (occupancy < OCC_W'(BUF_DEPTH));
    assign imem_addr = pc_reg;
    assign target_pc = redirect_pc & ~PC_WIDTH'(3);

    assign if_instr  = if_valid ? instr_buf[rd_ptr_reg] : '0;
    assign if_pc     = if_valid ? pc_buf[rd_ptr_reg] : '0;
    assign if_pc4    = if_valid ? (pc_buf[rd_ptr_reg] + PC_WIDTH'(4)) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            kill_reg        <= 1'b0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
        end else if (redirect_valid) begin
            pc_reg       <= target_pc;
            kill_reg     <= inflight_reg;
            inflight_reg <= 1'b0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            kill_reg     <= 1'b0;
            inflight_reg <= imem_req;
            if (imem_req) begin
                pc_reg          <= pc_reg + PC_WIDTH'(4);
                inflight_pc_reg <= pc_reg;
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                instr_buf[gi] <= imem_rdata;
                pc_buf[gi]    <= inflight_pc_reg;
            end
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0]      fetch_count_reg;
    logic [31:0]      flush_count_reg;
    logic [OCC_W-1:0] dropped;
    logic [32:0]      flush_sum;

    // Discards on redirect: entries ID did not take plus a live response still on the bus.
    assign dropped   = OCC_W'(count_reg) - OCC_W'(pop) + OCC_W'(live_rsp);
    assign flush_sum = {1'b0, flush_count_reg} + 33'(dropped);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (push && (fetch_count_reg != 32'hFFFF_FFFF))
                fetch_count_reg <= fetch_count_reg + 32'd1;
            if (redirect_valid)
                flush_count_reg <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end

    assign fetch_count = fetch_count_reg;
    assign flush_count = flush_count_reg;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule
